// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_arbiter
// Purpose  : Round-robin, packet-granular N:1 AXI-Stream arbiter.
//            Optional AXIS_ARBITER_SRC_TAG_EN stamps the one-hot grant into tuser.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128,
    parameter int TAG_OFFSET  = 16
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_reset,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_INPUTS*TDATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_INPUTS*TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                s_axis_tvalid,
    input  logic [NUM_INPUTS-1:0]                s_axis_tlast,
    output logic [NUM_INPUTS-1:0]                s_axis_tready,
    output logic [TDATA_WIDTH-1:0]               m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic [NUM_INPUTS-1:0]                grant,
    output logic                                 busy
);

    localparam int c_IDX_W  = $clog2(NUM_INPUTS);
    localparam int c_KEEP_W = TDATA_WIDTH / 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_grant_idx;
    logic [c_IDX_W-1:0]   w_grant_idx_nxt;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   w_last_grant_nxt;
    logic [c_IDX_W-1:0]   w_rr_sel;
    logic                 w_rr_hit;
    logic                 w_busy;
    logic                 w_sel_tvalid;
    logic                 w_sel_tlast;

    logic [TDATA_WIDTH-1:0] w_tdata [NUM_INPUTS];
    logic [c_KEEP_W-1:0]    w_tkeep [NUM_INPUTS];
    logic [TUSER_WIDTH-1:0] w_tuser [NUM_INPUTS];

    if (NUM_INPUTS < 2 || NUM_INPUTS > 8 || TAG_OFFSET + NUM_INPUTS > TUSER_WIDTH) begin : g_param_check
        $error("axis_packet_arbiter: illegal parameterisation");
    end

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
        assign w_tdata[gi] = s_axis_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
        assign w_tkeep[gi] = s_axis_tkeep[gi*c_KEEP_W +: c_KEEP_W];
        assign w_tuser[gi] = s_axis_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH];
    end

    // Scan downward so the candidate closest to last_grant+1 is written last and wins.
    always_comb begin
        logic [c_IDX_W-1:0] w_cand;
        w_rr_sel = '0;
        w_rr_hit = 1'b0;
        w_cand   = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            w_cand = c_IDX_W'((int'(r_last_grant) + k) % NUM_INPUTS);
            if (s_axis_tvalid[w_cand]) begin
                w_rr_sel = w_cand;
                w_rr_hit = 1'b1;
            end
        end
    end

    assign w_busy       = (r_state == S_BUSY);
    assign w_sel_tvalid = s_axis_tvalid[r_grant_idx];
    assign w_sel_tlast  = s_axis_tlast[r_grant_idx];

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_state      <= S_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= c_IDX_W'(NUM_INPUTS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant_idx  <= w_grant_idx_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_idx_nxt  = r_grant_idx;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_rr_hit) begin
                    w_state_nxt     = S_BUSY;
                    w_grant_idx_nxt = w_rr_sel;
                end
            end
            S_BUSY: begin
                if (w_sel_tvalid && m_axis_tready && w_sel_tlast) begin
                    w_state_nxt      = S_IDLE;
                    w_last_grant_nxt = r_grant_idx;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        grant         = '0;
        if (w_busy) begin
            s_axis_tready[r_grant_idx] = m_axis_tready;
            grant[r_grant_idx]         = 1'b1;
        end
    end

    assign busy          = w_busy;
    assign m_axis_tvalid = w_busy & w_sel_tvalid;
    assign m_axis_tlast  = w_sel_tlast;
    assign m_axis_tdata  = w_tdata[r_grant_idx];
    assign m_axis_tkeep  = w_tkeep[r_grant_idx];

`ifdef AXIS_ARBITER_SRC_TAG_EN
    always_comb begin
        m_axis_tuser                         = w_tuser[r_grant_idx];
        m_axis_tuser[TAG_OFFSET +: NUM_INPUTS] = grant;
    end
`else
    assign m_axis_tuser = w_tuser[r_grant_idx];
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_arbiter
// Purpose  : Self-checking bench: vector table, directed sequences, random run
//            against a packet-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_arbiter;

    localparam int N   = 4;
    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int KW  = DW / 8;
    localparam int TAG = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic            busy;

    axis_packet_arbiter #(
        .NUM_INPUTS (N),
        .TDATA_WIDTH(DW),
        .TUSER_WIDTH(UW),
        .TAG_OFFSET (TAG)
    ) u_dut (
        .axis_aclk    (clk),
        .axis_reset   (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: owner is -1 when no packet is in flight.
    int mo_owner = -1;
    int mo_last  = N - 1;
    bit mo_ok    = 1'b0;
    int nx_owner;
    int nx_last;

    // Snapshot of DUT outputs taken mid-cycle, used by directed checks.
    logic [N-1:0]  sg, sstr, svalid;
    logic          sb, smv, sml, smr;
    logic [DW-1:0] smt;
    logic [UW-1:0] smu;

    // Packet sources for the directed sequences.
    int src_rem  [N];
    int src_beat [N];
    bit src_hold [N];
    bit use_src = 1'b0;

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            src_rem[i]  = 0;
            src_beat[i] = 0;
            src_hold[i] = 1'b0;
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]            = (src_rem[i] > 0) && !src_hold[i];
            s_tlast[i]             = (src_rem[i] == 1);
            s_tdata[i*DW +: DW]    = {(DW/16){8'(i), 8'(src_beat[i])}};
            s_tkeep[i*KW +: KW]    = {(KW/8){8'(i*16 + src_beat[i])}};
            s_tuser[i*UW +: UW]    = '0;
        end
    endtask

    task automatic rand_payload();
        for (int w = 0; w < N*DW/32; w++) s_tdata[w*32 +: 32] = $urandom();
        for (int w = 0; w < N*KW/32; w++) s_tkeep[w*32 +: 32] = $urandom();
        for (int w = 0; w < N*UW/32; w++) s_tuser[w*32 +: 32] = $urandom();
    endtask

    task automatic model_check();
        logic [N-1:0]  eg, er;
        logic          emv;
        logic [UW-1:0] eu;
        eg  = '0;
        er  = '0;
        emv = 1'b0;
        if (mo_owner >= 0) begin
            eg[mo_owner] = 1'b1;
            er[mo_owner] = m_tready;
            emv          = s_tvalid[mo_owner];
        end
        chk("grant",    256'(sg),   256'(eg));
        chk("busy",     256'(sb),   256'(mo_owner >= 0));
        chk("s_tready", 256'(sstr), 256'(er));
        chk("m_tvalid", 256'(smv),  256'(emv));
        if (mo_owner >= 0) begin
            eu = s_tuser[mo_owner*UW +: UW];
`ifdef AXIS_ARBITER_SRC_TAG_EN
            eu[TAG +: N] = eg;
`endif
            chk("m_tdata", 256'(smt),     256'(s_tdata[mo_owner*DW +: DW]));
            chk("m_tkeep", 256'(m_tkeep), 256'(s_tkeep[mo_owner*KW +: KW]));
            chk("m_tlast", 256'(sml),     256'(s_tlast[mo_owner]));
            chk("m_tuser", 256'(smu),     256'(eu));
        end
    endtask

    task automatic model_next();
        nx_owner = mo_owner;
        nx_last  = mo_last;
        if (rst) begin
            nx_owner = -1;
            nx_last  = N - 1;
        end else if (mo_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (nx_owner < 0 && s_tvalid[(mo_last + k) % N]) nx_owner = (mo_last + k) % N;
            end
        end else if (s_tvalid[mo_owner] && m_tready && s_tlast[mo_owner]) begin
            nx_last  = mo_owner;
            nx_owner = -1;
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, check, then cross the edge.
    task automatic cycle();
        if (use_src) apply_src();
        #2;
        sg = grant; sstr = s_tready; svalid = s_tvalid; sb = busy; smv = m_tvalid;
        sml = m_tlast; smr = m_tready; smt = m_tdata; smu = m_tuser;
        if (mo_ok) model_check();
        model_next();
        @(posedge clk);
        if (mo_ok || rst) begin
            mo_owner = nx_owner;
            mo_last  = nx_last;
            mo_ok    = 1'b1;
        end
        if (use_src) begin
            for (int i = 0; i < N; i++) begin
                if (svalid[i] && sstr[i]) begin
                    src_rem[i]--;
                    src_beat[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] tv;
        logic         mr;
        logic [N-1:0] eg;
        logic         eb;
        logic         emv;
    } vec_t;

    vec_t         tbl [19];
    logic [N-1:0] e30 [8];
    byte          got [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{4'hF, 1'b1, 4'h1, 1'b1, 1'b1};
        tbl[2]  = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{4'hF, 1'b1, 4'h2, 1'b1, 1'b1};
        tbl[4]  = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{4'hF, 1'b1, 4'h4, 1'b1, 1'b1};
        tbl[6]  = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{4'hF, 1'b1, 4'h8, 1'b1, 1'b1};
        tbl[8]  = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{4'hF, 1'b1, 4'h1, 1'b1, 1'b1};
        tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[11] = '{4'h0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[12] = '{4'h4, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{4'h4, 1'b0, 4'h4, 1'b1, 1'b1};
        tbl[14] = '{4'h0, 1'b1, 4'h4, 1'b1, 1'b0};
        tbl[15] = '{4'h4, 1'b1, 4'h4, 1'b1, 1'b1};
        tbl[16] = '{4'hA, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[17] = '{4'h8, 1'b1, 4'h8, 1'b1, 1'b1};
        tbl[18] = '{4'h0, 1'b1, 4'h0, 1'b0, 1'b0};
        e30 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4};

        rst = 1'b1; m_tready = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        clr_src();

        // Two 3-beat packets from inputs 0 and 2 after reset.
        use_src = 1'b1;
        do_reset();
        src_rem[0] = 3;
        src_rem[2] = 3;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk($sformatf("s30_grant_c%0d", c + 1), 256'(sg), 256'(e30[c]));
            if (c >= 1 && c <= 3) chk($sformatf("s30_beat_c%0d", c + 1), 256'(smt[15:0]), 256'({8'd0, 8'(c - 1)}));
            if (c >= 5)           chk($sformatf("s30_beat_c%0d", c + 1), 256'(smt[15:0]), 256'({8'd2, 8'(c - 5)}));
        end

        // Vector table: continuous 1-beat packets, idle gaps, stalls.
        use_src = 1'b0;
        clr_src();
        s_tvalid = '0;
        do_reset();
        for (int r = 0; r < 19; r++) begin
            s_tvalid = tbl[r].tv;
            s_tlast  = '1;
            m_tready = tbl[r].mr;
            rand_payload();
            cycle();
            chk($sformatf("tbl%0d_grant", r),  256'(sg),  256'(tbl[r].eg));
            chk($sformatf("tbl%0d_busy", r),   256'(sb),  256'(tbl[r].eb));
            chk($sformatf("tbl%0d_mvalid", r), 256'(smv), 256'(tbl[r].emv));
        end

        // Granted input 1 stalls mid-packet while input 3 waits.
        use_src = 1'b1;
        m_tready = 1'b1;
        clr_src();
        do_reset();
        src_rem[1] = 4;
        src_rem[3] = 2;
        cycle(); chk("s32_idle", 256'(sg), 256'(4'h0));
        cycle(); chk("s32_grant", 256'(sg), 256'(4'h2));
        chk("s32_beat0", 256'(smt[15:0]), 256'(16'h0100));
        src_hold[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk($sformatf("s32_hold%0d_grant", c), 256'(sg), 256'(4'h2));
            chk($sformatf("s32_hold%0d_mvalid", c), 256'(smv), 256'(1'b0));
        end
        src_hold[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk($sformatf("s32_run%0d_grant", c), 256'(sg), 256'(4'h2));
        end
        chk("s32_tlast", 256'(sml), 256'(1'b1));
        cycle(); chk("s32_gap", 256'(sg), 256'(4'h0));
        cycle(); chk("s32_next", 256'(sg), 256'(4'h8));

        // Backpressure toggling during a 4-beat packet from input 2.
        clr_src();
        do_reset();
        src_rem[2] = 4;
        got.delete();
        for (int c = 0; c < 20 && src_rem[2] > 0; c++) begin
            m_tready = (c % 2 == 1);
            cycle();
            if (sb) chk($sformatf("s33_ready_c%0d", c), 256'(sstr[2]), 256'(smr));
            if (smv && smr) got.push_back(byte'(smt[7:0]));
        end
        chk("s33_done", 256'(src_rem[2] == 0), 256'(1'b1));
        chk("s33_count", 256'(got.size()), 256'(4));
        foreach (got[k]) chk($sformatf("s33_order%0d", k), 256'(got[k]), 256'(k));

        // Reset in the middle of a 5-beat packet.
        m_tready = 1'b1;
        clr_src();
        do_reset();
        src_rem[0] = 5;
        src_rem[1] = 1;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clr_src();
        src_rem[0] = 2;
        src_rem[1] = 1;
        cycle();
        chk("s34_grant", 256'(sg), 256'(4'h0));
        chk("s34_busy", 256'(sb), 256'(1'b0));
        chk("s34_ready", 256'(sstr), 256'(4'h0));
        cycle();
        chk("s34_rearb", 256'(sg), 256'(4'h1));

        // Source tag on input 3 with zero tuser.
        clr_src();
        do_reset();
        src_rem[3] = 2;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (smv) begin
`ifdef AXIS_ARBITER_SRC_TAG_EN
                chk($sformatf("s35_tuser_c%0d", c), 256'(smu), 256'(UW'(4'b1000) << TAG));
`else
                chk($sformatf("s35_tuser_c%0d", c), 256'(smu), 256'(0));
`endif
            end
        end

        // Random traffic against the reference model.
        use_src = 1'b0;
        clr_src();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                s_tvalid[i] = ($urandom_range(0, 9) < 7);
                s_tlast[i]  = ($urandom_range(0, 2) == 0);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            rand_payload();
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
